param_alu_core: RTL and testbench

PARAM_ALU_CORE -- requirements
Module: param_alu_core

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/param_alu_core.sv | 194 +++++++++++++++++++
 tb/tb_param_alu_core.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the parameterised ALU core: op codes, FSM states and
// flag bit positions inside the 4-bit {Z,N,C,V} flags word.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NAND  = 4'd5,
    OP_NOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SRA   = 4'd10,
    OP_ROL   = 4'd11,
    OP_MUL   = 4'd12,
    OP_SLT   = 4'd13,
    OP_PASSB = 4'd14,
    OP_MAXU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: one partial product per enabled
// cycle, WIDTH iterations after start. Operands must be held stable by the caller.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;

  always_comb begin
    addend  = '0;
    if (b[cnt]) addend = {{WIDTH{1'b0}}, a} << cnt;
    acc_nxt = acc + addend;
  end

  // done flags the iteration that finishes the product; product is the
  // accumulator value that iteration will write, so the caller can latch it.
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (ena) begin
      if (start) begin
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        acc <= acc_nxt;
        cnt <= cnt + CW'(1);
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_alu_core.sv
// Parameterised ALU core with valid/ready request and result handshakes;
// single-cycle ops complete at acceptance, MUL runs on the sequential multiplier.
module param_alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [3:0]         flags,
  output alu_state_e         state_dbg
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  // Handshakes: a request transfers on an enabled edge with in_valid && in_ready;
  // a result transfers on an enabled edge with out_valid && out_ready. Both
  // sides hold their payload stable until the transfer edge.

  alu_state_e         state;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic               mul_fire;
  logic [2*WIDTH-1:0] mul_product;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     wide;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;
  logic [3:0]         mul_flags;

  assign in_ready  = ena && (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (alu_op_e'(op) == OP_MUL);
  assign mul_fire  = (state == ST_EXEC) && (op_q == OP_MUL) && mul_busy && mul_done;
  assign sh        = b[SHW-1:0];
  assign state_dbg = state;

  // Single-cycle datapath works on the live request so its result can be
  // registered on the acceptance edge itself.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    sra_w   = '0;
    case (alu_op_e'(op))
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        wide    = {1'b0, a} - {1'b0, b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = ~wide[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NAND:  alu_res = ~(a & b);
      OP_NOR:   alu_res = ~(a | b);
      OP_NOT:   alu_res = ~a;
      OP_SHL: begin
        wide    = {1'b0, a} << sh;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      OP_SHR: begin
        wide    = {a, 1'b0} >> sh;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      OP_SRA: begin
        // The guard bit below the LSB catches the last bit shifted out.
        sra_w   = $signed({a, 1'b0}) >>> sh;
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      OP_ROL: begin
        alu_res = (a << sh) | (a >> (WIDTH - int'(sh)));
        alu_c   = (sh != '0) && alu_res[0];
      end
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASSB: alu_res = b;
      OP_MAXU:  alu_res = (a > b) ? a : b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_N] = mul_product[2*WIDTH-1];
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alu_op_e'(op);
            if (alu_op_e'(op) == OP_MUL) begin
              state <= ST_EXEC;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              result_hi <= '0;
              flags     <= alu_flags;
            end
          end
        end
        ST_EXEC: begin
          if (mul_fire) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            flags     <= mul_flags;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu_core.sv
// Bench for param_alu_core at WIDTH=8: directed vectors with hand-computed
// results, handshake/stall/reset scenarios, and a random back-to-back run.
module tb_param_alu_core;
  import alu_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           ena = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [3:0]     op = '0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   result;
  logic [W-1:0]   result_hi;
  logic [3:0]     flags;
  alu_state_e     state_dbg;

  int n_cmp = 0;
  int n_mis = 0;
  logic [2*W+3:0] exp_q[$];

  param_alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model: {Z,N,C,V, hi, lo} ----------------
  function automatic logic [2*W+3:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, s, sh, lim_hi, lim_lo;
    logic [W-1:0] lo, hi, t;
    logic [2*W-1:0] p;
    logic c, v, z, n;
    lo = '0; hi = '0; c = 1'b0; v = 1'b0; t = x; p = '0;
    sx = $signed(x); sy = $signed(y);
    sh = int'(y) % W;
    lim_hi = (1 << (W - 1)) - 1;
    lim_lo = -(1 << (W - 1));
    case (o)
      OP_ADD:   begin s = int'(x) + int'(y); lo = W'(s); c = (s >= (1 << W)); v = (sx + sy > lim_hi) || (sx + sy < lim_lo); end
      OP_SUB:   begin s = int'(x) - int'(y); lo = W'(s); c = (x >= y); v = (sx - sy > lim_hi) || (sx - sy < lim_lo); end
      OP_AND:   lo = x & y;
      OP_OR:    lo = x | y;
      OP_XOR:   lo = x ^ y;
      OP_NAND:  lo = ~(x & y);
      OP_NOR:   lo = ~(x | y);
      OP_NOT:   lo = ~x;
      OP_SHL:   begin for (int i = 0; i < sh; i++) begin c = t[W-1]; t = t << 1; end lo = t; end
      OP_SHR:   begin for (int i = 0; i < sh; i++) begin c = t[0]; t = t >> 1; end lo = t; end
      OP_SRA:   begin for (int i = 0; i < sh; i++) begin c = t[0]; t = {t[W-1], t[W-1:1]}; end lo = t; end
      OP_ROL:   begin for (int i = 0; i < sh; i++) begin c = t[W-1]; t = {t[W-2:0], t[W-1]}; end lo = t; end
      OP_MUL:   begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; hi = p[2*W-1:W]; lo = p[W-1:0]; c = (hi != '0); v = c; end
      OP_SLT:   lo = (sx < sy) ? W'(1) : '0;
      OP_PASSB: lo = y;
      default:  lo = (x > y) ? x : y;
    endcase
    z = (o == OP_MUL) ? ({hi, lo} == '0) : (lo == '0);
    n = (o == OP_MUL) ? hi[W-1] : lo[W-1];
    return {z, n, c, v, hi, lo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns the number of negedges after the acceptance edge until out_valid (-1 on timeout).
  task automatic wait_valid(input int budget, output int lat, output logic ready_seen);
    lat = -1;
    ready_seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [2*W+3:0] got;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {flags, result_hi, result};
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (got !== '0) begin n_mis++; $display("FAIL reset_outputs: got %h want 0", got); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    ena = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL ena_low_in_ready: got %b want 0", in_ready); end
    ena = 1'b1;
  endtask

  task automatic test_ops;
    logic [3:0]     t_op [16] = '{OP_ADD, OP_SUB, OP_SRA, OP_ADD, OP_SHL, OP_SHL, OP_SHR, OP_ROL,
                                  OP_SLT, OP_MAXU, OP_NOR, OP_MUL, OP_SUB, OP_NAND, OP_SRA, OP_ROL};
    logic [W-1:0]   t_a  [16] = '{8'hFF, 8'h80, 8'h90, 8'h7F, 8'hA5, 8'h81, 8'h81, 8'h81,
                                  8'h80, 8'h7F, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h90, 8'h81};
    logic [W-1:0]   t_b  [16] = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h08, 8'h01, 8'h01, 8'h01,
                                  8'h01, 8'h80, 8'h00, 8'h37, 8'h02, 8'hFF, 8'h08, 8'h00};
    logic [2*W+3:0] t_e  [16] = '{20'hA_00_00, 20'h3_00_7F, 20'h4_00_E4, 20'h5_00_80,
                                  20'h4_00_A5, 20'h2_00_02, 20'h2_00_40, 20'h2_00_03,
                                  20'h0_00_01, 20'h4_00_80, 20'h4_00_FF, 20'h8_00_00,
                                  20'h4_00_FF, 20'h8_00_00, 20'h4_00_90, 20'h4_00_81};
    logic [2*W+3:0] got, exp;
    int lat, want_lat;
    logic rs;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(t_e[i]);
      send(t_op[i], t_a[i], t_b[i]);
      wait_valid(30, lat, rs);
      want_lat = (t_op[i] == OP_MUL) ? W + 1 : 1;
      n_cmp++; if (lat != want_lat) begin n_mis++; $display("FAIL op%0d_latency: got %0d want %0d", i, lat, want_lat); end
      got = {flags, result_hi, result};
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL op%0d_result: got %h want %h", i, got, exp); end
      release_out();
    end
  endtask

  task automatic test_mul_latency;
    logic [2*W+3:0] got, exp;
    int lat;
    logic rs;
    exp_q.push_back(20'h7_FE_01);
    send(OP_MUL, 8'hFF, 8'hFF);
    wait_valid(30, lat, rs);
    n_cmp++; if (lat != 9) begin n_mis++; $display("FAIL mul_latency: got %0d want 9", lat); end
    n_cmp++; if (rs !== 1'b0) begin n_mis++; $display("FAIL mul_in_ready_busy: got %b want 0", rs); end
    got = {flags, result_hi, result};
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL mul_result: got %h want %h", got, exp); end
    release_out();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL mul_out_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL mul_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure;
    logic [2*W+3:0] got, exp;
    int lat, rises;
    logic rs;
    exp_q.push_back(model(OP_ADD, 8'h35, 8'h4C));
    send(OP_ADD, 8'h35, 8'h4C);
    wait_valid(10, lat, rs);
    n_cmp++; if (lat != 1) begin n_mis++; $display("FAIL bp_latency: got %0d want 1", lat); end
    op = OP_MUL; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      got = {flags, result_hi, result};
      n_cmp++; if (got !== exp_q[0]) begin n_mis++; $display("FAIL bp_hold%0d_result: got %h want %h", k, got, exp_q[0]); end
      n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_mis++; $display("FAIL bp_hold%0d_handshake: got %b want 10", k, {out_valid, in_ready}); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    got = {flags, result_hi, result};
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL bp_result: got %h want %h", got, exp); end
    release_out();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_complete: got %b want 0", out_valid); end
    n_cmp++; if (state_dbg !== ST_IDLE) begin n_mis++; $display("FAIL bp_state: got %0d want %0d", state_dbg, ST_IDLE); end
    rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    n_cmp++; if (rises != 0) begin n_mis++; $display("FAIL bp_ignored_request: got %0d completions want 0", rises); end
    got = {flags, result_hi, result};
    n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL bp_outputs_kept: got %h want %h", got, exp); end
  endtask

  task automatic test_ena_stall;
    logic [2*W+3:0] got, exp;
    int lat;
    exp_q.push_back(model(OP_MUL, 8'h5A, 8'hC3));
    send(OP_MUL, 8'h5A, 8'hC3);
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) ena = 1'b0;
      if (i == 6) ena = 1'b1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    ena = 1'b1;
    n_cmp++; if (lat != 12) begin n_mis++; $display("FAIL stall_latency: got %0d want 12", lat); end
    got = {flags, result_hi, result};
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL stall_result: got %h want %h", got, exp); end
    release_out();
  endtask

  task automatic test_reset_mid_mul;
    logic [2*W+3:0] got;
    int rises;
    send(OP_MUL, 8'hFF, 8'hFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {flags, result_hi, result};
    n_cmp++; if (got !== '0) begin n_mis++; $display("FAIL rst_mul_outputs: got %h want 0", got); end
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL rst_mul_out_valid: got %b want 0", out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL rst_mul_in_ready: got %b want 1", in_ready); end
    rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    n_cmp++; if (rises != 0) begin n_mis++; $display("FAIL rst_mul_no_result: got %0d completions want 0", rises); end
  endtask

  task automatic test_back_to_back;
    logic [2*W+3:0] got, exp;
    logic [3:0]     o;
    logic [W-1:0]   x, y;
    int lat, want_lat;
    logic rs;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = W'($urandom_range(0, 255));
      y = W'($urandom_range(0, 255));
      exp_q.push_back(model(o, x, y));
      send(o, x, y);
      wait_valid(30, lat, rs);
      want_lat = (o == OP_MUL) ? W + 1 : 1;
      n_cmp++; if (lat != want_lat) begin n_mis++; $display("FAIL rnd%0d_latency op=%0d: got %0d want %0d", i, o, lat, want_lat); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      got = {flags, result_hi, result};
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_mis++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, x, y, got, exp); end
      release_out();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ops();
    test_mul_latency();
    test_backpressure();
    test_ena_stall();
    test_reset_mid_mul();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
